// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: operation encoding and the
// bit layout of the registered status flags.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'b000,
        OP_INC    = 3'b001,
        OP_JUMP   = 3'b010,
        OP_BRANCH = 3'b011,
        OP_CALL   = 3'b100,
        OP_RET    = 3'b101,
        OP_RSV6   = 3'b110,
        OP_RSV7   = 3'b111
    } op_e;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_FAULT = 2;
    localparam int STAT_W     = 3;

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO. count_q is the only state the flags depend on, so
// full/empty follow count in the cycle it changes.
module pc_return_stack
    import pc_sequencer_pkg::*;
#(
    parameter int N           = 6,
    parameter int STACK_DEPTH = 4,
    localparam int CW         = $clog2(STACK_DEPTH + 1),
    localparam int AW         = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          push,
    input  logic          pop,
    input  logic [N-1:0]  push_data,
    output logic [N-1:0]  top_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [N-1:0]  mem_q [STACK_DEPTH];
    logic [N-1:0]  mem_d [STACK_DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] top_idx;

    assign full     = (count_q == CW'(STACK_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign top_idx  = count_q - CW'(1);
    assign top_data = mem_q[top_idx[AW-1:0]];

    // Requests against a full/empty stack are ignored here as well, so the
    // stack stays consistent even if a caller forgets to guard them.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[count_q[AW-1:0]] = push_data;
            count_d                = count_q + CW'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, next-PC mux and sticky fault,
// with a return-address stack for CALL/RET.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int N            = 6,
    parameter int STACK_DEPTH  = 4,
    parameter int RESET_VECTOR = 0
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Enable,
    input  logic [2:0]   Op,
    input  logic [N-1:0] Target,
    input  logic [N-1:0] Offset,
    output logic [N-1:0] PC_Output,
    output logic         Stack_Full,
    output logic         Stack_Empty,
    output logic         Fault
);

    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [N-1:0]      pc_q, pc_d;
    logic              fault_q, fault_d;
    logic              push, pop;
    logic [N-1:0]      pc_inc, top_data;
    logic [CW-1:0]     count;
    logic              full, empty, can_push, can_pop;
    logic [STAT_W-1:0] status;
    op_e               op;

    assign op       = op_e'(Op);
    assign pc_inc   = pc_q + N'(1);
    assign can_push = (count != CW'(STACK_DEPTH));
    assign can_pop  = (count != '0);

    // Offset is already N bits wide, so sign extension to N is the identity
    // and plain modular addition gives the two's-complement displacement.
    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (Enable) begin
            case (op)
                OP_HOLD:   pc_d = pc_q;
                OP_INC:    pc_d = pc_inc;
                OP_JUMP:   pc_d = Target;
                OP_BRANCH: pc_d = pc_inc + Offset;
                OP_CALL: begin
                    if (can_push) begin
                        push = 1'b1;
                        pc_d = Target;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (can_pop) begin
                        pop  = 1'b1;
                        pc_d = top_data;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
                default:   fault_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_q    <= N'(RESET_VECTOR);
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    pc_return_stack #(
        .N          (N),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .Clock    (Clock),
        .Reset    (Reset),
        .push     (push),
        .pop      (pop),
        .push_data(pc_inc),
        .top_data (top_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        status             = '0;
        status[STAT_FULL]  = full;
        status[STAT_EMPTY] = empty;
        status[STAT_FAULT] = fault_q;
    end

    assign PC_Output   = pc_q;
    assign Stack_Full  = status[STAT_FULL];
    assign Stack_Empty = status[STAT_EMPTY];
    assign Fault       = status[STAT_FAULT];

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (N=6, STACK_DEPTH=4, RESET_VECTOR=0).
module tb_pc_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Enable = 1'b0;
    logic [2:0] Op = 3'b000;
    logic [5:0] Target = '0;
    logic [5:0] Offset = '0;
    logic [5:0] PC_Output;
    logic       Stack_Full, Stack_Empty, Fault;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, JUMP = 3'b010,
                           BRANCH = 3'b011, CALL = 3'b100, RET = 3'b101,
                           RSV = 3'b110;

    pc_sequencer #(.N(6), .STACK_DEPTH(4), .RESET_VECTOR(0)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Enable     (Enable),
        .Op         (Op),
        .Target     (Target),
        .Offset     (Offset),
        .PC_Output  (PC_Output),
        .Stack_Full (Stack_Full),
        .Stack_Empty(Stack_Empty),
        .Fault      (Fault)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit
    // after the rising edge that executed the operation.
    task automatic step(input logic en, input logic [2:0] op,
                        input logic [5:0] tgt, input logic [5:0] off);
        @(negedge Clock);
        Enable = en;
        Op     = op;
        Target = tgt;
        Offset = off;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset  = 1'b1;
        Enable = 1'b0;
        #1;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_pc", PC_Output, 0);
        check("rst_empty", Stack_Empty, 1);
        check("rst_full", Stack_Full, 0);
        check("rst_fault", Fault, 0);
        @(negedge Clock);
        Reset = 1'b0;

        // Build PC=37 with one stack entry, then reset between edges
        step(1, CALL, 6'd36, 0);        // push 1
        check("call36_pc", PC_Output, 36);
        step(1, INC, 0, 0);
        check("inc_pc37", PC_Output, 37);
        check("inc_empty0", Stack_Empty, 0);
        @(negedge Clock);
        Op    = INC;
        Reset = 1'b1;
        #1;
        check("async_pc", PC_Output, 0);
        check("async_empty", Stack_Empty, 1);
        check("async_fault", Fault, 0);
        @(negedge Clock);
        Reset = 1'b0;

        // Wrap and branch
        step(1, JUMP, 6'd63, 0);
        check("jump63", PC_Output, 63);
        step(1, INC, 0, 0);
        check("wrap_pc", PC_Output, 0);
        check("wrap_fault", Fault, 0);
        step(1, JUMP, 6'd10, 0);
        step(1, BRANCH, 0, 6'b111100);
        check("branch_neg", PC_Output, 7);
        step(1, BRANCH, 0, 6'd60);       // 7+1+60 = 68 mod 64 = 4
        check("branch_wrap", PC_Output, 4);

        // Single call/return
        step(1, JUMP, 6'd5, 0);
        step(1, CALL, 6'd20, 0);
        check("call_pc", PC_Output, 20);
        check("call_empty", Stack_Empty, 0);
        step(1, RET, 0, 0);
        check("ret_pc", PC_Output, 6);
        check("ret_empty", Stack_Empty, 1);

        // Fill the stack: pushes 7, 9, 17, 25
        step(1, CALL, 6'd8, 0);
        step(1, CALL, 6'd16, 0);
        step(1, CALL, 6'd24, 0);
        check("call3_full", Stack_Full, 0);
        step(1, CALL, 6'd32, 0);
        check("call4_pc", PC_Output, 32);
        check("call4_full", Stack_Full, 1);
        check("call4_fault", Fault, 0);
        step(1, CALL, 6'd40, 0);
        check("ovf_pc", PC_Output, 32);
        check("ovf_fault", Fault, 1);
        check("ovf_full", Stack_Full, 1);
        step(1, RET, 0, 0);
        check("ret1", PC_Output, 25);
        check("ret1_full", Stack_Full, 0);
        step(1, RET, 0, 0);
        check("ret2", PC_Output, 17);
        step(1, RET, 0, 0);
        check("ret3", PC_Output, 9);
        step(1, RET, 0, 0);
        check("ret4", PC_Output, 7);
        check("ret4_empty", Stack_Empty, 1);
        check("fault_sticky", Fault, 1);

        // Underflow and reserved op
        do_reset();
        check("rst2_fault", Fault, 0);
        step(1, RET, 0, 0);
        check("unf_pc", PC_Output, 0);
        check("unf_fault", Fault, 1);
        check("unf_empty", Stack_Empty, 1);
        do_reset();
        step(1, INC, 0, 0);
        step(1, RSV, 6'd9, 0);
        check("rsv_pc", PC_Output, 1);
        check("rsv_fault", Fault, 1);
        step(1, INC, 0, 0);
        step(1, HOLD, 0, 0);
        check("hold_pc", PC_Output, 2);
        check("fault_persist", Fault, 1);
        do_reset();
        check("rst3_fault", Fault, 0);

        // Stalls
        step(0, JUMP, 6'd50, 0);
        check("stall_jump_pc", PC_Output, 0);
        step(0, CALL, 6'd12, 0);
        check("stall_call_pc", PC_Output, 0);
        check("stall_call_empty", Stack_Empty, 1);
        step(0, RSV, 0, 0);
        check("stall_rsv_fault", Fault, 0);
        step(1, JUMP, 6'd50, 0);
        check("unstall_jump", PC_Output, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
